// File: rtl/msf_frame_sync.sv
// msf_frame_sync: locks to the MSF minute marker and slices the 10 Hz sample stream
// into seconds, extracting the A/B bits and flagging frame violations.
module msf_frame_sync #(
  parameter logic OFF_LEVEL  = 1'b1,
  parameter int   MARKER_MIN = 4,
  parameter int   MARKER_MAX = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       bit_i,
  input  logic       valid_i,
  output logic       synced_o,
  output logic [5:0] second_o,
  output logic       a_o,
  output logic       b_o,
  output logic       bit_valid_o,
  output logic       minute_o,
  output logic       err_o
);
  localparam logic [2:0] MK_MIN = 3'(MARKER_MIN);
  localparam logic [2:0] MK_MAX = 3'(MARKER_MAX);
  typedef enum logic {HUNT, SYNC} state_t;
  state_t     state;
  logic [2:0] off_run;
  logic [3:0] slot;
  logic [5:0] second;
  logic       a_cap, b_cap;
  logic       off, on, marker, short_run;
  always_comb begin
    off       = valid_i && bit_i == OFF_LEVEL;
    on        = valid_i && bit_i != OFF_LEVEL;
    marker    = on && off_run != 3'd7 && off_run >= MK_MIN && off_run <= MK_MAX;
    short_run = off_run != 3'd0 && off_run < MK_MIN;
  end
  assign synced_o = state == SYNC;
  // the marker's terminating on-sample occupies slot 5, so the next sample is slot 6
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= HUNT;
      off_run     <= 3'd0;
      slot        <= 4'd0;
      second      <= 6'd0;
      a_cap       <= 1'b0;
      b_cap       <= 1'b0;
      second_o    <= 6'd0;
      a_o         <= 1'b0;
      b_o         <= 1'b0;
      bit_valid_o <= 1'b0;
      minute_o    <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      bit_valid_o <= 1'b0;
      minute_o    <= 1'b0;
      err_o       <= 1'b0;
      if (valid_i) begin
        off_run <= off ? (off_run == 3'd7 ? 3'd7 : off_run + 3'd1) : 3'd0;
        if (state == HUNT) begin
          if (marker) begin
            state    <= SYNC;
            second   <= 6'd0;
            slot     <= 4'd6;
            minute_o <= 1'b1;
          end
        end else if (marker && second != 6'd0) begin
          err_o  <= 1'b1;
          second <= 6'd0;
          slot   <= 4'd6;
        end else if (marker) begin
          minute_o <= 1'b1;
          slot     <= 4'd6;
        end else if (on && (slot == 4'd0 || (second == 6'd0 && short_run))) begin
          err_o <= 1'b1;
          state <= HUNT;
        end else begin
          if (slot == 4'd1) a_cap <= off;
          if (slot == 4'd2) b_cap <= off;
          if (slot == 4'd9 && second != 6'd0) begin
            a_o         <= a_cap;
            b_o         <= b_cap;
            second_o    <= second;
            bit_valid_o <= 1'b1;
          end
          slot   <= slot == 4'd9 ? 4'd0 : slot + 4'd1;
          second <= slot != 4'd9 ? second : (second == 6'd59 ? 6'd0 : second + 6'd1);
        end
      end
    end
  end
endmodule
